// File: rtl/ks_sum_capture_stage.sv
// ============================================================================
//  Module      : ks_sum_capture_stage
//  Description : Registered output stage for the 8-bit Kogge-Stone adder.
//                Captures SUM/Cout plus zero, negative and signed-overflow
//                flags into a 2-entry skid buffer behind a valid/ready
//                interface, and counts delivered results.
//                Optional macro KS_SUM_OVF_COUNT_EN adds a saturating
//                counter (ovf_count) of delivered results with out_v=1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ks_sum_capture_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SUM,
    input  logic             Cout,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v,
    output logic [CNT_W-1:0] txn_count
`ifdef KS_SUM_OVF_COUNT_EN
    ,
    output logic [7:0]       ovf_count
`endif
);

    // Entry layout: {v, n, z, cout, sum}
    localparam int c_ENT_W = WIDTH + 4;
    localparam int c_COUT  = WIDTH;
    localparam int c_Z     = WIDTH + 1;
    localparam int c_N     = WIDTH + 2;
    localparam int c_V     = WIDTH + 3;

    localparam logic [1:0] c_S_EMPTY = 2'd0;
    localparam logic [1:0] c_S_ONE   = 2'd1;
    localparam logic [1:0] c_S_FULL  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_ENT_W-1:0] r_main;
    logic [c_ENT_W-1:0] r_skid;
    logic [c_ENT_W-1:0] w_in_entry;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_load_main_in;
    logic               w_load_main_skid;
    logic               w_load_skid;
    logic [CNT_W-1:0]   r_txn_count;

    // Build the entry from the adder outputs, flags derived at capture time
    always_comb begin
        w_in_entry                = '0;
        w_in_entry[WIDTH-1:0]     = SUM;
        w_in_entry[c_COUT]        = Cout;
        w_in_entry[c_Z]           = (SUM == '0);
        w_in_entry[c_N]           = SUM[WIDTH-1];
        w_in_entry[c_V]           = (a_msb == b_msb) && (SUM[WIDTH-1] != a_msb);
    end

    // Handshake outputs; in_ready comes only from state, rst and flush
    always_comb begin
        in_ready   = (r_state != c_S_FULL) && !rst && !flush;
        out_valid  = (r_state != c_S_EMPTY) && !rst;
        w_in_fire  = in_valid && in_ready;
        w_out_fire = out_valid && out_ready;
        out_sum    = r_main[WIDTH-1:0];
        out_cout   = r_main[c_COUT];
        out_z      = r_main[c_Z];
        out_n      = r_main[c_N];
        out_v      = r_main[c_V];
        txn_count  = r_txn_count;
    end

    // Next-state and buffer load decisions
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            c_S_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt    = c_S_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            c_S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = c_S_FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = c_S_EMPTY;
                end
            end
            c_S_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt      = c_S_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_S_EMPTY;
            end
        endcase
    end

    // State register; rst and flush both return to EMPTY
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= c_S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // MAIN/SKID storage; discarded entries are zeroed
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_in_entry;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    // Delivered-result counter; flush-cycle deliveries still count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txn_count <= '0;
        end else if (w_out_fire) begin
            r_txn_count <= r_txn_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef KS_SUM_OVF_COUNT_EN
    logic [7:0] r_ovf_count;

    // Saturating count of delivered overflow results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_count <= 8'd0;
        end else if (w_out_fire && r_main[c_V] && (r_ovf_count != 8'hFF)) begin
            r_ovf_count <= r_ovf_count + 8'd1;
        end
    end

    assign ovf_count = r_ovf_count;
`endif

endmodule

`default_nettype wire
